seg_scan_driver: RTL and testbench

Parametrised time-multiplexed seven-segment scan driver for N-digit common-anode displays. It generalises the fixed four-digit display multiplexer with:
- a configurable digit count and refresh rate,
- per-digit decimal points,
- PWM brightness control,
- optional leading-zero blanking,
- frame-synchronous (tear-free) input capture.

It sits between the datapath registers and the 4-bit-to-seven-segment decoder on the BASYS2/BASYS3 top levels.

---
 rtl/seg_scan_driver.sv | 106 ++++++++++
 tb/tb_seg_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver: PWM brightness, per-digit
// decimal points, leading-zero blanking and frame-synchronous input capture.
module seg_scan_driver #(
  parameter int NDIGITS          = 4,
  parameter int TICKW            = 18,
  parameter int BRW              = 4,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4*NDIGITS-1:0]         digits,
  input  logic [NDIGITS-1:0]           blank,
  input  logic [NDIGITS-1:0]           dp,
  input  logic [BRW-1:0]               brightness,
  input  logic                         lzb,
  output logic [3:0]                   muxd,
  output logic                         dpo,
  output logic [NDIGITS-1:0]           adrive,
  output logic [$clog2(NDIGITS)-1:0]   digit_idx,
  output logic                         frame_tick
);

  localparam int              IW      = $clog2(NDIGITS);
  localparam logic [IW-1:0]   LAST    = IW'(NDIGITS - 1);
  localparam bit              ACT_LOW = (ANODE_ACTIVE_LOW != 0);
  localparam logic [NDIGITS-1:0] IDLE = ACT_LOW ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

  // Digit i is blanked when it and every digit above it are zero; digit 0 never is.
  function automatic logic [NDIGITS-1:0] lzb_mask(input logic [4*NDIGITS-1:0] d);
    logic [NDIGITS-1:0] m;
    logic               run;
    m   = '0;
    run = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      run  = run & (d[4*i +: 4] == 4'd0);
      m[i] = run;
    end
    return m;
  endfunction

  logic [TICKW-1:0]   cnt;
  logic [IW-1:0]      idx;
  logic [3:0]         sh_nib [NDIGITS];
  logic [NDIGITS-1:0] sh_blank;
  logic [NDIGITS-1:0] sh_dp;
  logic [BRW-1:0]     sh_bright;

  logic               frame_start;
  logic               slot_end;
  logic               lit_p0;
  logic [NDIGITS-1:0] sel_p0;

  assign frame_start = (cnt == '0) && (idx == LAST);
  assign slot_end    = &cnt;

  // Stage p0: slot timer and scan index (leftmost digit first)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= LAST;
    end else begin
      cnt <= cnt + TICKW'(1);
      if (slot_end)
        idx <= (idx == '0) ? LAST : idx - IW'(1);
    end
  end

  // Shadow capture only at frame start keeps each frame tear-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIGITS; i++) sh_nib[i] <= 4'd0;
      sh_blank  <= '1;
      sh_dp     <= '0;
      sh_bright <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NDIGITS; i++) sh_nib[i] <= digits[4*i +: 4];
      sh_blank  <= blank | (lzb ? lzb_mask(digits) : '0);
      sh_dp     <= dp;
      sh_bright <= brightness;
    end
  end

  always_comb begin
    lit_p0      = ~sh_blank[idx] && (cnt[TICKW-1 -: BRW] < sh_bright);
    sel_p0      = '0;
    sel_p0[idx] = lit_p0;
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      muxd       <= 4'd0;
      dpo        <= 1'b0;
      adrive     <= IDLE;
      digit_idx  <= LAST;
      frame_tick <= 1'b0;
    end else begin
      muxd       <= sh_nib[idx];
      dpo        <= lit_p0 & sh_dp[idx];
      adrive     <= ACT_LOW ? ~sel_p0 : sel_p0;
      digit_idx  <= idx;
      frame_tick <= slot_end && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a frame/slot arithmetic model checked every cycle,
// plus directed cases with hand-computed expectations, both anode polarities.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank, dp;
  logic [1:0]  brightness;
  logic        lzb;

  logic [3:0]  muxd, muxd2, adrive, adrive2;
  logic        dpo, dpo2, ft, ft2;
  logic [1:0]  didx, didx2;

  seg_scan_driver #(.NDIGITS(4), .TICKW(4), .BRW(2), .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .blank(blank), .dp(dp),
    .brightness(brightness), .lzb(lzb), .muxd(muxd), .dpo(dpo),
    .adrive(adrive), .digit_idx(didx), .frame_tick(ft));

  seg_scan_driver #(.NDIGITS(4), .TICKW(4), .BRW(2), .ANODE_ACTIVE_LOW(0)) dut2 (
    .clk(clk), .reset(reset), .digits(digits), .blank(blank), .dp(dp),
    .brightness(brightness), .lzb(lzb), .muxd(muxd2), .dpo(dpo2),
    .adrive(adrive2), .digit_idx(didx2), .frame_tick(ft2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge k after reset release sits at slot k/16, count k%16; frames are 64 edges.
  int         k;
  int         m_c, m_id, m_hi;
  bit         m_lit;
  logic [3:0] m_dig [4];
  logic [3:0] m_blank, m_dp;
  logic [1:0] m_br;
  logic [3:0] e_mux, e_an, e_anl;
  logic [1:0] e_idx;
  logic       e_dpo, e_ft;
  bit         chk_en = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      k = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_blank = 4'hF; m_dp = 4'h0; m_br = 2'd0;
      e_mux = 4'd0; e_an = 4'h0; e_anl = 4'hF; e_dpo = 1'b0; e_ft = 1'b0; e_idx = 2'd3;
    end else begin
      m_c   = k % 16;
      m_id  = 3 - (k / 16) % 4;
      m_lit = !m_blank[m_id] && ((m_c / 4) < m_br);
      e_mux = m_dig[m_id];
      e_an  = m_lit ? (4'b0001 << m_id) : 4'b0000;
      e_anl = ~e_an;
      e_dpo = m_lit && m_dp[m_id];
      e_idx = m_id[1:0];
      e_ft  = (k % 64 == 63);
      if (k % 64 == 0) begin
        m_hi = -1;
        for (int i = 0; i < 4; i++) if (digits[4*i +: 4] != 4'd0) m_hi = i;
        m_blank = blank;
        if (lzb) for (int i = 1; i < 4; i++) if (i > m_hi) m_blank[i] = 1'b1;
        for (int i = 0; i < 4; i++) m_dig[i] = digits[4*i +: 4];
        m_dp = dp;
        m_br = brightness;
      end
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("muxd", muxd, e_mux);
      chk("muxd_hi", muxd2, e_mux);
      chk("adrive", adrive, e_anl);
      chk("adrive_hi", adrive2, e_an);
      chk("dpo", dpo, e_dpo);
      chk("dpo_hi", dpo2, e_dpo);
      chk("digit_idx", didx, e_idx);
      chk("digit_idx_hi", didx2, e_idx);
      chk("frame_tick", ft, e_ft);
      chk("frame_tick_hi", ft2, e_ft);
    end
  end

  int last_e;
  int on_cnt [4];
  int dp_cnt, ft_cnt, ft_at, dark_cnt;

  task automatic step();
    @(negedge clk);
    last_e++;
  endtask

  task automatic go_to(input int e);
    while (last_e < e) step();
  endtask

  task automatic collect();
    logic [3:0] pat;
    for (int d = 0; d < 4; d++) on_cnt[d] = 0;
    dp_cnt = 0; ft_cnt = 0; ft_at = -1; dark_cnt = 0;
    repeat (64) begin
      step();
      for (int d = 0; d < 4; d++) begin
        pat = ~(4'b0001 << d);
        if (adrive == pat) on_cnt[d]++;
      end
      if (adrive == 4'hF) dark_cnt++;
      if (dpo) dp_cnt++;
      if (ft) begin ft_cnt++; ft_at = last_e; end
    end
  endtask

  task automatic run_case(input logic [15:0] a_dig, input logic [3:0] a_blank,
                          input logic [3:0] a_dp, input logic [1:0] a_br, input logic a_lzb);
    int cap;
    digits = a_dig; blank = a_blank; dp = a_dp; brightness = a_br; lzb = a_lzb;
    cap = (last_e / 64 + 1) * 64;
    go_to(cap);
    collect();
  endtask

  initial begin
    digits = 16'h1234; blank = 4'h0; dp = 4'h0; brightness = 2'd3; lzb = 1'b0;
    last_e = -1;
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_adrive", adrive, 4'hF);
    chk("rst_adrive_hi", adrive2, 4'h0);
    chk("rst_idx", didx, 2'd3);
    chk("rst_muxd", muxd, 4'd0);
    chk("rst_dpo", dpo, 1'b0);
    chk("rst_tick", ft, 1'b0);
    reset = 1'b0;

    // Scan order and frame timing
    step();       chk("first_dark", adrive, 4'hF);
    step();       chk("first_lit_mux", muxd, 4'h1);
                  chk("first_lit_an", adrive, 4'b0111);
    go_to(63);    chk("tick_63", ft, 1'b1);
    collect();
    chk("scan_on3", on_cnt[3], 12);
    chk("scan_on2", on_cnt[2], 12);
    chk("scan_on1", on_cnt[1], 12);
    chk("scan_on0", on_cnt[0], 12);
    chk("scan_ticks", ft_cnt, 1);
    chk("scan_tick_at", ft_at, 127);
    chk("scan_dark", dark_cnt, 16);

    // Tear-free capture
    go_to(140);   digits = 16'hABCD;
    go_to(150);   chk("tear_mid", muxd, 4'h2);
    go_to(191);   chk("tear_last", muxd, 4'h4);
    go_to(192);   chk("tear_edge", muxd, 4'h1);
    go_to(193);   chk("tear_new", muxd, 4'hA);

    // Leading-zero blanking
    run_case(16'h0070, 4'h0, 4'h0, 2'd3, 1'b1);
    chk("lzb70_on3", on_cnt[3], 0);
    chk("lzb70_on2", on_cnt[2], 0);
    chk("lzb70_on1", on_cnt[1], 12);
    chk("lzb70_on0", on_cnt[0], 12);
    run_case(16'h0000, 4'h0, 4'h0, 2'd3, 1'b1);
    chk("lzb0_on1", on_cnt[1], 0);
    chk("lzb0_on0", on_cnt[0], 12);
    run_case(16'h0000, 4'h0, 4'h0, 2'd3, 1'b0);
    chk("nolzb_on3", on_cnt[3], 12);

    // Brightness
    run_case(16'h1234, 4'h0, 4'h0, 2'd1, 1'b0);
    chk("br1_on3", on_cnt[3], 4);
    chk("br1_on0", on_cnt[0], 4);
    run_case(16'h1234, 4'h0, 4'h0, 2'd0, 1'b0);
    chk("br0_dark", dark_cnt, 64);

    // Decimal point
    run_case(16'h1234, 4'h0, 4'b0100, 2'd3, 1'b0);
    chk("dp_cnt", dp_cnt, 12);
    chk("dp_on2", on_cnt[2], 12);
    run_case(16'h1234, 4'b0100, 4'b0100, 2'd3, 1'b0);
    chk("dpblank_cnt", dp_cnt, 0);
    chk("dpblank_on2", on_cnt[2], 0);

    // Asynchronous reset between edges
    digits = 16'h5678; blank = 4'h0; dp = 4'h0; brightness = 2'd3; lzb = 1'b0;
    go_to(last_e + 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_adrive", adrive, 4'hF);
    chk("async_adrive_hi", adrive2, 4'h0);
    chk("async_dpo", dpo, 1'b0);
    chk("async_tick", ft, 1'b0);
    step();
    step();
    chk("async_idx", didx, 2'd3);
    reset = 1'b0;
    last_e = -1;
    step();       chk("rel_dark", adrive, 4'hF);
    step();       chk("rel_mux", muxd, 4'h5);
                  chk("rel_an", adrive, 4'b0111);
    go_to(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
